// File: rtl/mcu_spi_arbiter_if.sv
// Bundle between the SPI arbiter, its requesters and the SPIMux.
// The master side drives requests; the arbiter is the slave.
interface mcu_spi_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0] Req;
    logic [NUM_REQ-1:0] Grant;
    logic [NUM_REQ-1:0] Abort;
    logic [NUM_REQ-1:0] InSel;
    logic [NUM_REQ-1:0] InDo;
    logic [NUM_REQ-1:0] InClkRunning;
    logic [NUM_REQ-1:0] InClkStretch;
    logic [NUM_REQ-1:0] ReqReadyFallingEdge;
    logic               MCUReadyFallingEdge;
    logic               nMCUSel;
    logic               SPIDo;
    logic               SPIClkRunning;
    logic               SPIClkStretch;

    modport master (
        output Req,
        output InSel,
        output InDo,
        output InClkRunning,
        output InClkStretch,
        output MCUReadyFallingEdge,
        input  Grant,
        input  Abort,
        input  ReqReadyFallingEdge,
        input  nMCUSel,
        input  SPIDo,
        input  SPIClkRunning,
        input  SPIClkStretch
    );

    modport slave (
        input  Req,
        input  InSel,
        input  InDo,
        input  InClkRunning,
        input  InClkStretch,
        input  MCUReadyFallingEdge,
        output Grant,
        output Abort,
        output ReqReadyFallingEdge,
        output nMCUSel,
        output SPIDo,
        output SPIClkRunning,
        output SPIClkStretch
    );
endinterface

// File: rtl/mcu_spi_arbiter.sv
// Round-robin arbiter sharing one MCU SPI link between requesters,
// with a select guard gap and a ready-edge timeout abort.
module mcu_spi_arbiter #(
    parameter int          NUM_REQ        = 2,
    parameter int          GUARD_CYCLES   = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input logic              SClk,
    input logic              nRst,
    mcu_spi_arbiter_if.slave bus
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GUARD = 2'd2
    } state_t;

    // The IDLE arbitration cycle is the last cycle of the guard gap,
    // so GUARD itself lasts GUARD_CYCLES-1 cycles.
    localparam state_t     REL_STATE  = (GUARD_CYCLES > 1) ? GUARD : IDLE;
    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 2);

    state_t              state;
    state_t              state_n;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  grant_n;
    logic [NUM_REQ-1:0]  abort;
    logic [NUM_REQ-1:0]  abort_n;
    logic [NUM_REQ-1:0]  blocked;
    logic [NUM_REQ-1:0]  blocked_n;
    logic [NUM_REQ-1:0]  elig;
    logic [IW-1:0]       gidx;
    logic [IW-1:0]       gidx_n;
    logic [IW-1:0]       last;
    logic [IW-1:0]       last_n;
    logic [IW-1:0]       win;
    logic [IW-1:0]       cand_idx;
    logic                found;
    int                  cand;
    logic [15:0]         tmo_cnt;
    logic [15:0]         tmo_n;
    logic [15:0]         tmo_inc;
    logic [3:0]          grd_cnt;
    logic [3:0]          grd_n;
    logic                act;
    logic                rst_sync;

    // Reset asserts asynchronously; release takes effect one edge later.
    always_ff @(posedge SClk or negedge nRst) begin
        if (!nRst) begin
            rst_sync <= 1'b0;
        end else begin
            rst_sync <= 1'b1;
        end
    end

    assign elig = bus.Req & ~blocked;

    always_comb begin
        win      = last;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last) + k) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!found && elig[cand_idx]) begin
                win   = cand_idx;
                found = 1'b1;
            end
        end
    end

    assign tmo_inc = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
    assign act     = bus.MCUReadyFallingEdge | bus.InClkRunning[gidx];

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        gidx_n    = gidx;
        last_n    = last;
        abort_n   = '0;
        tmo_n     = tmo_cnt;
        grd_n     = grd_cnt;
        blocked_n = blocked & bus.Req;
        if (rst_sync) begin
            unique case (state)
                IDLE: begin
                    if (|elig) begin
                        grant_n      = '0;
                        grant_n[win] = 1'b1;
                        gidx_n       = win;
                        tmo_n        = '0;
                        state_n      = GRANT;
                    end
                end
                GRANT: begin
                    tmo_n = act ? 16'd0 : tmo_inc;
                    if (!act && tmo_inc == TIMEOUT_CYCLES) begin
                        abort_n[gidx]   = 1'b1;
                        blocked_n[gidx] = 1'b1;
                        grant_n         = '0;
                        last_n          = gidx;
                        grd_n           = '0;
                        state_n         = REL_STATE;
                    end else if (!bus.Req[gidx] && bus.InSel[gidx]) begin
                        // Never release while the requester still selects.
                        grant_n = '0;
                        last_n  = gidx;
                        grd_n   = '0;
                        state_n = REL_STATE;
                    end
                end
                GUARD: begin
                    grd_n = grd_cnt + 4'd1;
                    if (grd_cnt == GUARD_LAST) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    grant_n = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge SClk or negedge nRst) begin
        if (!nRst) begin
            state   <= IDLE;
            grant   <= '0;
            gidx    <= '0;
            last    <= IW'(NUM_REQ - 1);
            abort   <= '0;
            blocked <= '0;
            tmo_cnt <= '0;
            grd_cnt <= '0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            gidx    <= gidx_n;
            last    <= last_n;
            abort   <= abort_n;
            blocked <= blocked_n;
            tmo_cnt <= tmo_n;
            grd_cnt <= grd_n;
        end
    end

    assign bus.Grant = grant;
    assign bus.Abort = abort;

    always_comb begin
        bus.nMCUSel             = 1'b1;
        bus.SPIDo               = 1'b1;
        bus.SPIClkRunning       = 1'b0;
        bus.SPIClkStretch       = 1'b0;
        bus.ReqReadyFallingEdge = '0;
        if (state == GRANT) begin
            bus.nMCUSel             = bus.InSel[gidx];
            bus.SPIDo               = bus.InDo[gidx];
            bus.SPIClkRunning       = bus.InClkRunning[gidx];
            bus.SPIClkStretch       = bus.InClkStretch[gidx];
            bus.ReqReadyFallingEdge =
                grant & {NUM_REQ{bus.MCUReadyFallingEdge}};
        end
    end

endmodule

// File: tb/tb_mcu_spi_arbiter.sv
// Directed bench for mcu_spi_arbiter: grant order, guard gap,
// muxing, ready steering, timeout abort and async reset.
module tb_mcu_spi_arbiter;

    logic SClk;
    logic nRst;
    int   n_chk;
    int   n_err;
    int   gap;
    int   k;
    int   bad;

    mcu_spi_arbiter_if #(.NUM_REQ(2)) bus ();

    mcu_spi_arbiter #(
        .NUM_REQ(2),
        .GUARD_CYCLES(4),
        .TIMEOUT_CYCLES(16'd16)
    ) dut (
        .SClk(SClk),
        .nRst(nRst),
        .bus(bus)
    );

    initial begin
        SClk = 1'b0;
        forever #5 SClk = ~SClk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge SClk);
        #1;
    endtask

    task automatic count_gap();
        gap = 0;
        while (bus.Grant == 2'b00 && gap < 20) begin
            if (bus.nMCUSel !== 1'b1) bad++;
            gap++;
            step(1);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        bad   = 0;
        nRst  = 1'b0;
        bus.Req                 = 2'b00;
        bus.InSel               = 2'b11;
        bus.InDo                = 2'b00;
        bus.InClkRunning        = 2'b00;
        bus.InClkStretch        = 2'b00;
        bus.MCUReadyFallingEdge = 1'b0;
        #3;
        check("rst_grant", 32'(bus.Grant), 32'd0);
        check("rst_abort", 32'(bus.Abort), 32'd0);
        check("rst_sel", 32'(bus.nMCUSel), 32'd1);
        check("rst_do", 32'(bus.SPIDo), 32'd1);
        check("rst_run", 32'(bus.SPIClkRunning), 32'd0);
        check("rst_str", 32'(bus.SPIClkStretch), 32'd0);

        step(2);
        nRst    = 1'b1;
        bus.Req = 2'b11;
        step(1);
        check("sync_nogrant", 32'(bus.Grant), 32'd0);
        step(1);
        check("first_grant", 32'(bus.Grant), 32'd1);

        bus.InDo         = 2'b10;
        bus.InClkRunning = 2'b01;
        bus.InClkStretch = 2'b10;
        #1;
        check("g0_sel", 32'(bus.nMCUSel), 32'd1);
        check("g0_do", 32'(bus.SPIDo), 32'd0);
        check("g0_run", 32'(bus.SPIClkRunning), 32'd1);
        check("g0_str", 32'(bus.SPIClkStretch), 32'd0);
        step(2);
        bus.Req          = 2'b10;
        bus.InClkRunning = 2'b00;
        step(1);
        count_gap();
        check("gap_01_10", 32'(gap), 32'd4);
        check("gap_sel", 32'(bad), 32'd0);
        check("second_grant", 32'(bus.Grant), 32'd2);

        bus.InSel = 2'b01;
        #1;
        check("g1_sel", 32'(bus.nMCUSel), 32'd0);
        check("g1_do_hi", 32'(bus.SPIDo), 32'd1);
        check("g1_str", 32'(bus.SPIClkStretch), 32'd1);
        bus.InDo = 2'b00;
        bus.MCUReadyFallingEdge = 1'b1;
        #1;
        check("g1_do_lo", 32'(bus.SPIDo), 32'd0);
        check("rdy_steer", 32'(bus.ReqReadyFallingEdge), 32'd2);
        step(1);
        bus.MCUReadyFallingEdge = 1'b0;
        #1;
        check("rdy_pulse", 32'(bus.ReqReadyFallingEdge), 32'd0);
        bus.Req = 2'b00;
        step(2);
        check("hold_on_sel", 32'(bus.Grant), 32'd2);
        bus.InSel = 2'b11;
        step(1);
        check("rel_grant", 32'(bus.Grant), 32'd0);
        bus.MCUReadyFallingEdge = 1'b1;
        #1;
        check("rdy_guard", 32'(bus.ReqReadyFallingEdge), 32'd0);
        bus.MCUReadyFallingEdge = 1'b0;
        bus.InClkStretch        = 2'b00;
        step(6);

        bus.Req = 2'b01;
        step(1);
        check("tmo_grant", 32'(bus.Grant), 32'd1);
        k = 0;
        while (bus.Abort == 2'b00 && k < 40) begin
            step(1);
            k++;
        end
        check("tmo_cycles", 32'(k), 32'd16);
        check("tmo_abort", 32'(bus.Abort), 32'd1);
        check("tmo_ungrant", 32'(bus.Grant), 32'd0);
        step(1);
        check("abort_pulse", 32'(bus.Abort), 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.Grant != 2'b00) bad++;
            step(1);
        end
        check("no_regrant", 32'(bad), 32'd0);
        bus.Req = 2'b00;
        step(1);
        bus.Req = 2'b01;
        step(1);
        check("regrant", 32'(bus.Grant), 32'd1);
        bus.Req = 2'b00;
        step(6);

        bus.Req = 2'b10;
        step(1);
        check("pre_rst_grant", 32'(bus.Grant), 32'd2);
        bus.InSel = 2'b01;
        #1;
        check("pre_rst_sel", 32'(bus.nMCUSel), 32'd0);
        #1;
        nRst = 1'b0;
        #1;
        check("arst_sel", 32'(bus.nMCUSel), 32'd1);
        check("arst_grant", 32'(bus.Grant), 32'd0);
        check("arst_abort", 32'(bus.Abort), 32'd0);
        step(1);
        nRst      = 1'b1;
        bus.Req   = 2'b11;
        bus.InSel = 2'b11;
        step(2);
        check("post_rst", 32'(bus.Grant), 32'd1);

        for (int r = 0; r < 4; r++) begin
            logic [1:0] g;
            g = (r % 2 == 0) ? 2'b01 : 2'b10;
            check($sformatf("rr_grant%0d", r), 32'(bus.Grant), 32'(g));
            step(7);
            bus.Req = ~g;
            step(1);
            bus.Req = 2'b11;
            bad = 0;
            count_gap();
            check($sformatf("rr_gap%0d", r), 32'(gap), 32'd4);
        end
        check("rr_final", 32'(bus.Grant), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
